// File: rtl/mcpu_core_pkg.sv
// Shared constants for the core data-cache arbiter: state codes,
// cache bus widths and a small one-hot helper.
package mcpu_core_pkg;

    localparam int DC_ADDR_W = 30;
    localparam int DC_MASK_W = 4;
    localparam int DC_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY0 = 2'b01,
        ST_BUSY1 = 2'b10
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mcpu_core_dcache_arb_if.sv
// Bundle of the two requester ports and the single cache port.
// slave: arbiter view; master: requesters plus cache model view.
interface mcpu_core_dcache_arb_if;
    import mcpu_core_pkg::*;

    logic [1:0]                req_valid;
    logic [1:0][DC_ADDR_W-1:0] req_paddr;
    logic [1:0][DC_MASK_W-1:0] req_write;
    logic [1:0][DC_DATA_W-1:0] req_wdata;
    logic [1:0]                req_done;
    logic [DC_DATA_W-1:0]      req_rdata;

    logic                      dc_valid;
    logic [DC_ADDR_W-1:0]      dc_paddr;
    logic [DC_MASK_W-1:0]      dc_write;
    logic [DC_DATA_W-1:0]      dc_wdata;
    logic                      dc_done;
    logic [DC_DATA_W-1:0]      dc_rdata;

    modport slave (
        input  req_valid, req_paddr, req_write, req_wdata,
        input  dc_done, dc_rdata,
        output req_done, req_rdata,
        output dc_valid, dc_paddr, dc_write, dc_wdata
    );

    modport master (
        output req_valid, req_paddr, req_write, req_wdata,
        output dc_done, dc_rdata,
        input  req_done, req_rdata,
        input  dc_valid, dc_paddr, dc_write, dc_wdata
    );

endinterface

// File: rtl/mcpu_core_rr_pick2.sv
// Combinational 2-way round-robin picker.
// req/excl in, last_grant in; one-hot gnt and any out.
module mcpu_core_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic [1:0] excl,
    output logic [1:0] gnt,
    output logic       any
);

    logic [1:0] eff;

    always_comb begin
        eff = req & ~excl;
        gnt = eff;
        unique case (1'b1)
            (eff == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
            default:        gnt = eff;
        endcase
        any = |eff;
    end

endmodule

// File: rtl/mcpu_core_dcache_arb.sv
// Arbitrates the data-cache port between mem stage (0) and PTW (1).
// Ports: clk/rst, bus (slave), err_clr, sticky err flags, grant_dbg.
module mcpu_core_dcache_arb #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16
) (
    input  logic                         clkrst_core_clk,
    input  logic                         clkrst_core_rst,
    mcpu_core_dcache_arb_if.slave        bus,
    input  logic                         err_clr,
    output logic                         err_proto,
    output logic                         err_timeout,
    output logic [1:0]                   grant_dbg
);
    import mcpu_core_pkg::*;

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             err_proto_q, err_proto_d;
    logic             err_timeout_q, err_timeout_d;

    logic       busy;
    logic       cur;
    logic       cur_valid;
    logic       viol;
    logic       fin;
    logic       rearb;
    logic [1:0] excl;
    logic [1:0] pick_gnt;
    logic       pick_any;

    mcpu_core_rr_pick2 u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .excl       (excl),
        .gnt        (pick_gnt),
        .any        (pick_any)
    );

    // Grant decode and cache-side datapath.
    always_comb begin
        busy = 1'b0;
        cur  = 1'b0;
        case (state_q)
            ST_BUSY0: begin
                busy = 1'b1;
                cur  = 1'b0;
            end
            ST_BUSY1: begin
                busy = 1'b1;
                cur  = 1'b1;
            end
            default: begin
                busy = 1'b0;
                cur  = 1'b0;
            end
        endcase

        cur_valid = busy & bus.req_valid[cur];
        viol      = busy & ~bus.req_valid[cur];
        fin       = cur_valid & bus.dc_done;
        // A dropped valid is treated like a completion for re-arbitration.
        rearb     = ~busy | viol | bus.dc_done;
        excl      = busy ? onehot2(cur) : 2'b00;

        bus.dc_valid  = cur_valid;
        bus.dc_paddr  = busy ? bus.req_paddr[cur] : '0;
        bus.dc_write  = busy ? bus.req_write[cur] : '0;
        bus.dc_wdata  = busy ? bus.req_wdata[cur] : '0;
        bus.req_done  = fin ? onehot2(cur) : 2'b00;
        bus.req_rdata = fin ? bus.dc_rdata : '0;
    end

    // Next state, watchdog and sticky flags.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (rearb) begin
            state_d = ST_IDLE;
            if (pick_any) begin
                state_d      = pick_gnt[1] ? ST_BUSY1 : ST_BUSY0;
                last_grant_d = pick_gnt[1];
            end
        end

        wd_cnt_d = wd_cnt_q;
        if (!busy || bus.dc_done) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != CNT_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        // Set has priority over clear.
        err_proto_d = err_clr ? 1'b0 : err_proto_q;
        if (viol) begin
            err_proto_d = 1'b1;
        end

        err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
        if (busy && !bus.dc_done && (wd_cnt_q >= TO_LIM)) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            wd_cnt_q      <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;
    assign grant_dbg   = state_q;

endmodule

// File: tb/tb_mcpu_core_dcache_arb.sv
// Self-checking bench for mcpu_core_dcache_arb: directed scenarios
// with literal expectations, then a randomized run against a model.
module tb_mcpu_core_dcache_arb;

    localparam int TO = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       err_clr = 1'b0;
    logic       err_proto;
    logic       err_timeout;
    logic [1:0] grant_dbg;

    mcpu_core_dcache_arb_if bus ();

    mcpu_core_dcache_arb #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (16)
    ) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .bus             (bus),
        .err_clr         (err_clr),
        .err_proto       (err_proto),
        .err_timeout     (err_timeout),
        .grant_dbg       (grant_dbg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: owner of the port (-1 none), last winner, busy-cycle
    // count without completion, sticky flags.
    int         m_g, n_g;
    bit         m_last, n_last;
    int         m_cnt, n_cnt;
    bit         m_ep, n_ep;
    bit         m_et, n_et;
    logic [1:0] m_done;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_g    = -1;
        m_last = 1'b1;
        m_cnt  = 0;
        m_ep   = 1'b0;
        m_et   = 1'b0;
        m_done = 2'b00;
    endtask

    // Compare all outputs mid-cycle and predict the next model state.
    task automatic eval();
        logic [1:0] rv;
        bit         busy, dcd, clr, c0, c1;
        @(negedge clk);
        rv   = bus.req_valid;
        dcd  = bus.dc_done;
        clr  = err_clr;
        busy = (m_g >= 0);

        m_done = 2'b00;
        if (busy && dcd && rv[m_g]) m_done = 2'b01 << m_g;

        if (busy) begin
            chk("dc_valid", 64'(bus.dc_valid), 64'(rv[m_g]));
            chk("dc_paddr", 64'(bus.dc_paddr), 64'(bus.req_paddr[m_g]));
            chk("dc_write", 64'(bus.dc_write), 64'(bus.req_write[m_g]));
            chk("dc_wdata", 64'(bus.dc_wdata), 64'(bus.req_wdata[m_g]));
            chk("grant_dbg", 64'(grant_dbg), 64'(m_g + 1));
        end else begin
            chk("dc_valid", 64'(bus.dc_valid), 64'd0);
            chk("dc_paddr", 64'(bus.dc_paddr), 64'd0);
            chk("dc_write", 64'(bus.dc_write), 64'd0);
            chk("dc_wdata", 64'(bus.dc_wdata), 64'd0);
            chk("grant_dbg", 64'(grant_dbg), 64'd0);
        end
        chk("req_done", 64'(bus.req_done), 64'(m_done));
        chk("req_rdata", 64'(bus.req_rdata),
            (m_done != 0) ? 64'(bus.dc_rdata) : 64'd0);
        chk("err_proto", 64'(err_proto), 64'(m_ep));
        chk("err_timeout", 64'(err_timeout), 64'(m_et));

        n_g    = m_g;
        n_last = m_last;
        if (!busy || !rv[m_g] || dcd) begin
            c0 = rv[0] && (m_g != 0);
            c1 = rv[1] && (m_g != 1);
            if (c0 && c1)  n_g = m_last ? 0 : 1;
            else if (c0)   n_g = 0;
            else if (c1)   n_g = 1;
            else           n_g = -1;
            if (n_g >= 0)  n_last = (n_g == 1);
        end
        if (!busy || dcd)       n_cnt = 0;
        else if (m_cnt < 65535) n_cnt = m_cnt + 1;
        else                    n_cnt = m_cnt;
        n_ep = clr ? 1'b0 : m_ep;
        if (busy && !rv[m_g]) n_ep = 1'b1;
        n_et = clr ? 1'b0 : m_et;
        if (busy && !dcd && m_cnt >= TO - 1) n_et = 1'b1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        m_g    = n_g;
        m_last = n_last;
        m_cnt  = n_cnt;
        m_ep   = n_ep;
        m_et   = n_et;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic new_req(input int i);
        bus.req_valid[i] = 1'b1;
        bus.req_paddr[i] = 30'($urandom);
        bus.req_write[i] = ($urandom_range(0, 1) == 0) ? 4'h0
                           : 4'($urandom_range(1, 15));
        bus.req_wdata[i] = $urandom;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_paddr = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.dc_done   = 1'b0;
        bus.dc_rdata  = '0;
        model_reset();

        #3;
        chk("rst_dc_valid", 64'(bus.dc_valid), 64'd0);
        chk("rst_grant", 64'(grant_dbg), 64'd0);
        chk("rst_err_proto", 64'(err_proto), 64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
        chk("rst_req_done", 64'(bus.req_done), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single read, done on third busy cycle.
        bus.req_valid    = 2'b01;
        bus.req_paddr[0] = 30'h100;
        bus.req_write[0] = 4'h0;
        eval();
        chk("rd_idle_valid", 64'(bus.dc_valid), 64'd0);
        adv();
        eval();
        chk("rd_dc_valid", 64'(bus.dc_valid), 64'd1);
        chk("rd_paddr", 64'(bus.dc_paddr), 64'h100);
        adv();
        eval();
        adv();
        bus.dc_done  = 1'b1;
        bus.dc_rdata = 32'hDEADBEEF;
        eval();
        chk("rd_done", 64'(bus.req_done), 64'h1);
        chk("rd_rdata", 64'(bus.req_rdata), 64'hDEADBEEF);
        adv();
        bus.req_valid = 2'b00;
        bus.dc_done   = 1'b0;
        bus.dc_rdata  = '0;
        eval();
        chk("rd_idle_after", 64'(grant_dbg), 64'd0);
        adv();

        // Contention from reset: 0, 1, then 0 again back-to-back.
        pulse_reset();
        bus.req_valid    = 2'b11;
        bus.req_paddr[0] = 30'h10;
        bus.req_paddr[1] = 30'h20;
        eval();
        adv();
        bus.dc_done  = 1'b1;
        bus.dc_rdata = 32'h11111111;
        eval();
        chk("ct_grant0", 64'(grant_dbg), 64'h1);
        chk("ct_done0", 64'(bus.req_done), 64'h1);
        adv();
        bus.req_paddr[0] = 30'h30;
        bus.dc_rdata     = 32'h22222222;
        eval();
        chk("ct_grant1", 64'(grant_dbg), 64'h2);
        chk("ct_done1", 64'(bus.req_done), 64'h2);
        adv();
        bus.req_valid = 2'b01;
        bus.dc_rdata  = 32'h33333333;
        eval();
        chk("ct_grant0_again", 64'(grant_dbg), 64'h1);
        chk("ct_done0_again", 64'(bus.req_done), 64'h1);
        adv();
        bus.req_valid = 2'b00;
        bus.dc_done   = 1'b0;
        eval();
        chk("ct_idle", 64'(grant_dbg), 64'd0);
        adv();

        // Write passthrough on requester 1.
        bus.req_valid    = 2'b10;
        bus.req_paddr[1] = 30'h2AA;
        bus.req_write[1] = 4'b1100;
        bus.req_wdata[1] = 32'h12345678;
        eval();
        adv();
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("wr_mask", 64'(bus.dc_write), 64'hC);
            chk("wr_data", 64'(bus.dc_wdata), 64'h12345678);
            adv();
        end
        bus.dc_done = 1'b1;
        eval();
        chk("wr_done", 64'(bus.req_done), 64'h2);
        chk("wr_mask_last", 64'(bus.dc_write), 64'hC);
        adv();
        bus.req_valid    = 2'b00;
        bus.dc_done      = 1'b0;
        bus.req_write[1] = 4'h0;
        bus.req_wdata[1] = '0;
        eval();
        adv();

        // Watchdog with TIMEOUT_CYC=4.
        bus.req_valid    = 2'b01;
        bus.req_paddr[0] = 30'h3C0;
        eval();
        adv();
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("to_flag_low", 64'(err_timeout), 64'd0);
            adv();
        end
        bus.dc_done  = 1'b1;
        bus.dc_rdata = 32'hCAFEF00D;
        eval();
        chk("to_flag_set", 64'(err_timeout), 64'd1);
        chk("to_late_done", 64'(bus.req_done), 64'h1);
        adv();
        bus.req_valid = 2'b00;
        bus.dc_done   = 1'b0;
        err_clr       = 1'b1;
        eval();
        chk("to_flag_held", 64'(err_timeout), 64'd1);
        adv();
        err_clr = 1'b0;
        eval();
        chk("to_flag_clr", 64'(err_timeout), 64'd0);
        adv();

        // Protocol error: req0 drops valid while req1 waits.
        bus.req_valid = 2'b01;
        eval();
        adv();
        bus.req_valid    = 2'b11;
        bus.req_paddr[1] = 30'h155;
        eval();
        chk("pe_grant0", 64'(grant_dbg), 64'h1);
        adv();
        bus.req_valid = 2'b10;
        eval();
        chk("pe_no_done", 64'(bus.req_done), 64'd0);
        adv();
        eval();
        chk("pe_flag", 64'(err_proto), 64'd1);
        chk("pe_grant1", 64'(grant_dbg), 64'h2);
        adv();

        // Reset in BUSY1 mid-cycle.
        eval();
        #2;
        rst         = 1'b1;
        bus.dc_done = 1'b1;
        #1;
        chk("rs_dc_valid", 64'(bus.dc_valid), 64'd0);
        chk("rs_grant", 64'(grant_dbg), 64'd0);
        chk("rs_err_proto", 64'(err_proto), 64'd0);
        chk("rs_err_timeout", 64'(err_timeout), 64'd0);
        chk("rs_no_done", 64'(bus.req_done), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        bus.dc_done   = 1'b0;
        eval();
        chk("rs_idle", 64'(grant_dbg), 64'd0);
        adv();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i]) begin
                    if (m_done[i]) begin
                        if ($urandom_range(0, 99) < 40) new_req(i);
                        else bus.req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 199) == 0) begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 30) begin
                    new_req(i);
                end
            end
            bus.dc_done = ($urandom_range(0, 99) <
                           ((c % 1000 < 200) ? 5 : 35));
            bus.dc_rdata = $urandom;
            err_clr      = ($urandom_range(0, 99) < 3);
            eval();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
